// File: rtl/seg7_scan.sv
// Six-digit time-multiplexed display scan controller with a small write port.
// Optional reverse scanning is enabled by defining SEG7_SCAN_REVERSE_EN.
module seg7_scan #(
   parameter int DIV   = 50000,
   parameter int CNT_W = 20
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wr_en,
   input  logic [2:0] wr_addr,
   input  logic [2:0] wr_data,
`ifdef SEG7_SCAN_REVERSE_EN
   input  logic       scan_dir,
`endif
   output logic       wr_err,
   output logic [2:0] digit_sel,
   output logic [2:0] digit_val,
   output logic       frame_tick
);

   localparam logic [CNT_W-1:0] LP_TC   = CNT_W'(DIV - 1);
   localparam logic [2:0]       LP_LAST = 3'd5;

   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_mem [6];
   logic [2:0]       r_sel;
   logic [2:0]       r_val;
   logic             r_tick;
   logic             r_err;

   logic             w_adv;
   logic             w_dir;
   logic             w_wr_ok;
   logic [2:0]       w_next_sel;
   logic [2:0]       w_start;
   logic [2:0]       w_next_val;

`ifdef SEG7_SCAN_REVERSE_EN
   assign w_dir = scan_dir;
`else
   assign w_dir = 1'b0;
`endif

   always_comb begin
      w_adv   = (r_cnt == LP_TC);
      w_wr_ok = wr_en && (wr_addr < 3'd6);
      w_start = w_dir ? LP_LAST : 3'd0;
      w_next_sel = r_sel;
      if (w_dir) begin
         w_next_sel = (r_sel == 3'd0) ? LP_LAST : r_sel - 3'd1;
      end else begin
         w_next_sel = (r_sel >= LP_LAST) ? 3'd0 : r_sel + 3'd1;
      end
      // A write landing on the digit about to be shown must win over stale storage.
      w_next_val = (w_wr_ok && (wr_addr == w_next_sel)) ? wr_data : r_mem[w_next_sel];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 6; i++) r_mem[i] <= '0;
      end else if (w_wr_ok) begin
         r_mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt  <= '0;
         r_sel  <= '0;
         r_val  <= '0;
         r_tick <= 1'b0;
         r_err  <= 1'b0;
      end else begin
         r_err  <= wr_en && (wr_addr >= 3'd6);
         r_tick <= 1'b0;
         if (w_adv) begin
            r_cnt  <= '0;
            r_sel  <= w_next_sel;
            r_val  <= w_next_val;
            r_tick <= (w_next_sel == w_start);
         end else begin
            r_cnt <= r_cnt + 1'b1;
            if (w_wr_ok && (wr_addr == r_sel)) r_val <= wr_data;
         end
      end
   end

   assign digit_sel  = r_sel;
   assign digit_val  = r_val;
   assign frame_tick = r_tick;
   assign wr_err     = r_err;

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan: randomized writes against a per-cycle
// behavioural model of the scan sequence and digit storage.
module tb_seg7_scan;

   localparam int DIV = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       wr_en = 1'b0;
   logic [2:0] wr_addr = '0;
   logic [2:0] wr_data = '0;
   logic       scan_dir = 1'b0;
   logic       wr_err;
   logic [2:0] digit_sel;
   logic [2:0] digit_val;
   logic       frame_tick;

   int errors = 0;
   int checks = 0;

   // model state
   int         ph;
   int         e_sel;
   logic       e_tick;
   logic       e_err;
   logic [2:0] mem [6];

   always #5 clk = ~clk;

   seg7_scan #(.DIV(DIV), .CNT_W(20)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
`ifdef SEG7_SCAN_REVERSE_EN
      .scan_dir   (scan_dir),
`endif
      .wr_err     (wr_err),
      .digit_sel  (digit_sel),
      .digit_val  (digit_val),
      .frame_tick (frame_tick)
   );

   task automatic model_reset();
      ph = 0;
      e_sel = 0;
      e_tick = 1'b0;
      e_err = 1'b0;
      for (int i = 0; i < 6; i++) mem[i] = 3'd0;
   endtask

   // One clock: apply inputs, step the model at the edge, return 1 ns later.
   task automatic cyc(input logic en, input logic [2:0] a, input logic [2:0] d);
      wr_en = en;
      wr_addr = a;
      wr_data = d;
      @(posedge clk);
      e_err = en && (a >= 3'd6);
      e_tick = 1'b0;
      if (ph == DIV - 1) begin
         ph = 0;
         e_sel = scan_dir ? (e_sel + 5) % 6 : (e_sel + 1) % 6;
         e_tick = (e_sel == (scan_dir ? 5 : 0));
      end else begin
         ph++;
      end
      if (en && a < 3'd6) mem[a] = d;
      #1;
   endtask

   task automatic test_reset();
      int nt;
      rst_n = 1'b0;
      wr_en = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({digit_sel, digit_val, frame_tick, wr_err} !== 8'd0) begin
         errors++;
         $display("FAIL reset_hold: got sel=%0d val=%0d tick=%0b err=%0b want all 0",
                  digit_sel, digit_val, frame_tick, wr_err);
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if (digit_sel !== 3'd0 || digit_val !== 3'd0 || frame_tick !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: got sel=%0d val=%0d tick=%0b want 0 0 0",
                  digit_sel, digit_val, frame_tick);
      end
      nt = 0;
      for (int c = 0; c < 12 * DIV; c++) begin
         cyc(1'b0, 3'd0, 3'd0);
         if (frame_tick === 1'b1) nt++;
         checks++;
         if (digit_sel !== 3'(e_sel) || frame_tick !== e_tick) begin
            errors++;
            $display("FAIL reset_scan c=%0d: got sel=%0d tick=%0b want sel=%0d tick=%0b",
                     c, digit_sel, frame_tick, e_sel, e_tick);
         end
      end
      checks++;
      if (nt != 2) begin
         errors++;
         $display("FAIL frame_tick_count: got %0d want 2", nt);
      end
   endtask

   task automatic test_fill();
      for (int a = 0; a < 6; a++) begin
         cyc(1'b1, 3'(a), 3'(7 - a));
         checks++;
         if (wr_err !== 1'b0) begin
            errors++;
            $display("FAIL fill_err a=%0d: got %0b want 0", a, wr_err);
         end
      end
      for (int c = 0; c < 6 * DIV; c++) begin
         cyc(1'b0, 3'd0, 3'd0);
         checks++;
         if (digit_sel !== 3'(e_sel) || digit_val !== 3'(7 - e_sel) || wr_err !== 1'b0) begin
            errors++;
            $display("FAIL fill_scan c=%0d: got sel=%0d val=%0d err=%0b want sel=%0d val=%0d err=0",
                     c, digit_sel, digit_val, wr_err, e_sel, 7 - e_sel);
         end
      end
   endtask

   task automatic test_illegal();
      cyc(1'b1, 3'd6, 3'd5);
      checks++;
      if (wr_err !== 1'b1) begin
         errors++;
         $display("FAIL illegal_err: got %0b want 1", wr_err);
      end
      cyc(1'b0, 3'd0, 3'd0);
      checks++;
      if (wr_err !== 1'b0) begin
         errors++;
         $display("FAIL illegal_err_clear: got %0b want 0", wr_err);
      end
      for (int c = 0; c < 6 * DIV; c++) begin
         cyc(1'b0, 3'd0, 3'd0);
         checks++;
         if (digit_sel !== 3'(e_sel) || digit_val !== 3'(7 - e_sel)) begin
            errors++;
            $display("FAIL illegal_frame c=%0d: got sel=%0d val=%0d want sel=%0d val=%0d",
                     c, digit_sel, digit_val, e_sel, 7 - e_sel);
         end
      end
   endtask

   task automatic test_bypass();
      int n = 0;
      while (!(ph == DIV - 1 && e_sel == 2) && n < 100) begin
         cyc(1'b0, 3'd0, 3'd0);
         n++;
      end
      checks++;
      if (n >= 100) begin
         errors++;
         $display("FAIL bypass_wait: got timeout want advance 2->3");
      end
      cyc(1'b1, 3'd3, 3'd1);
      checks++;
      if (digit_sel !== 3'd3 || digit_val !== 3'd1) begin
         errors++;
         $display("FAIL bypass: got sel=%0d val=%0d want sel=3 val=1", digit_sel, digit_val);
      end
      cyc(1'b1, 3'd3, 3'd6);
      checks++;
      if (digit_sel !== 3'd3 || digit_val !== 3'd6) begin
         errors++;
         $display("FAIL live_update: got sel=%0d val=%0d want sel=3 val=6", digit_sel, digit_val);
      end
      // Write the digit being left on the advance edge 3->4.
      while (ph != DIV - 1) cyc(1'b0, 3'd0, 3'd0);
      cyc(1'b1, 3'd3, 3'd2);
      checks++;
      if (digit_sel !== 3'd4 || digit_val !== mem[4]) begin
         errors++;
         $display("FAIL leave_write: got sel=%0d val=%0d want sel=4 val=%0d",
                  digit_sel, digit_val, mem[4]);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         cyc(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
         checks++;
         if (digit_sel !== 3'(e_sel) || digit_val !== mem[e_sel] ||
             frame_tick !== e_tick || wr_err !== e_err) begin
            errors++;
            $display("FAIL random c=%0d: got sel=%0d val=%0d tick=%0b err=%0b want sel=%0d val=%0d tick=%0b err=%0b",
                     c, digit_sel, digit_val, frame_tick, wr_err, e_sel, mem[e_sel], e_tick, e_err);
         end
      end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      while (!(e_sel == 4 && ph == 2) && n < 100) begin
         cyc(1'b0, 3'd0, 3'd0);
         n++;
      end
      checks++;
      if (n >= 100) begin
         errors++;
         $display("FAIL reset_mid_wait: got timeout want digit 4 cycle 2");
      end
      wr_en = 1'b1;
      wr_addr = 3'd4;
      wr_data = 3'd5;
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      checks++;
      if ({digit_sel, digit_val, frame_tick, wr_err} !== 8'd0) begin
         errors++;
         $display("FAIL reset_mid: got sel=%0d val=%0d tick=%0b err=%0b want all 0",
                  digit_sel, digit_val, frame_tick, wr_err);
      end
      wr_en = 1'b0;
      rst_n = 1'b1;
      for (int c = 0; c < 6 * DIV; c++) begin
         cyc(1'b0, 3'd0, 3'd0);
         checks++;
         if (digit_sel !== 3'(e_sel) || digit_val !== 3'd0) begin
            errors++;
            $display("FAIL reset_mid_scan c=%0d: got sel=%0d val=%0d want sel=%0d val=0",
                     c, digit_sel, digit_val, e_sel);
         end
      end
   endtask

`ifdef SEG7_SCAN_REVERSE_EN
   task automatic test_reverse();
      int n = 0;
      scan_dir = 1'b1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      model_reset();
      rst_n = 1'b1;
      for (int c = 0; c < 7 * DIV; c++) begin
         cyc(1'b0, 3'd0, 3'd0);
         checks++;
         if (digit_sel !== 3'(e_sel) || frame_tick !== e_tick) begin
            errors++;
            $display("FAIL reverse c=%0d: got sel=%0d tick=%0b want sel=%0d tick=%0b",
                     c, digit_sel, frame_tick, e_sel, e_tick);
         end
      end
      while (!(e_sel == 3 && ph == 1) && n < 100) begin
         cyc(1'b0, 3'd0, 3'd0);
         n++;
      end
      scan_dir = 1'b0;
      while (ph != 0 && n < 200) begin
         cyc(1'b0, 3'd0, 3'd0);
         n++;
      end
      checks++;
      if (digit_sel !== 3'd4 || n >= 100) begin
         errors++;
         $display("FAIL reverse_switch: got sel=%0d want 4", digit_sel);
      end
   endtask
`endif

   initial begin
      model_reset();
      test_reset();
      test_fill();
      test_illegal();
      test_bypass();
      test_random();
      test_reset_mid();
`ifdef SEG7_SCAN_REVERSE_EN
      test_reverse();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seg7_scan.md
Name: seg7_scan

Overview:
- Time-multiplexed scan controller for the 6-digit display.
- Holds one 3-bit value per digit and steps a digit index at a programmable rate.
- Drives the index and value codes that the display decoder turns into one-hot segment and digit-select lines:
  - digit_sel feeds the decoder's digit-select code input (data2).
  - digit_val feeds the decoder's segment code input (data1).
- Loaded from a simple write port by upstream logic.

Parameters:
- DIV, 50000, clk cycles each digit stays selected; legal range 2..2^20.
- CNT_W, 20, prescaler width; must satisfy 2^CNT_W >= DIV.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  write strobe, one write per cycle.
- wr_addr  input  3  target digit, 0..5.
- wr_data  input  3  value code to store.
- wr_err  output  1  one-cycle pulse: the previous cycle's write had wr_addr >= 6.
- digit_sel  output  3  current digit index, 0..5.
- digit_val  output  3  stored value of the digit in digit_sel.
- frame_tick  output  1  one-cycle pulse when the scan wraps back to its start digit.

Behaviour:
- Reset is asynchronous on rst_n low and clears:
  - all six stored values to 0;
  - the prescaler to 0;
  - digit_sel, digit_val, frame_tick and wr_err to 0.
- After rst_n deasserts, scanning resumes from digit 0 on the next edge.
- Prescaler:
  - Counts 0..DIV-1, then returns to 0.
  - The cycle in which it equals DIV-1 is the advance cycle.
- Advance cycle:
  - digit_sel steps 0,1,2,3,4,5,0 (wrap from 5 to 0).
  - digit_val is loaded with the stored value of the new index on the same edge.
  - Both outputs are registered and always change together; no cycle shows a mismatched pair.
- Dwell: each index is held for exactly DIV cycles, so one full frame is 6*DIV cycles.
- frame_tick is asserted for the single cycle after the edge on which digit_sel becomes the start digit (wrap 5->0).
- Writes:
  - With wr_en=1 and wr_addr in 0..5, the stored value for wr_addr takes wr_data on that edge.
  - With wr_en=1 and wr_addr in 6..7, storage is unchanged and wr_err=1 in the next cycle only.
- Write to the currently displayed digit (no advance that cycle): digit_val shows wr_data from the next cycle. Write-to-display latency is 1 cycle.
- Write to the digit being advanced to, in the advance cycle: digit_val takes wr_data, not the old stored value (bypass).
- Write to the digit being left, in the advance cycle: storage updates and digit_val follows the new digit; no glitch.
- Back-to-back writes to the same address: the last one wins, visible one cycle later.
- digit_sel never takes 6 or 7 in any cycle.
- Reset asserted mid-dwell or mid-write: the write is lost and all state returns to reset values immediately.

Optional Feature:
- Macro: SEG7_SCAN_REVERSE_EN.
- Defined:
  - Adds input port scan_dir (1 bit, placed after wr_data).
  - scan_dir=0: scan 0->5, wrap to 0, frame_tick on the wrap to 0.
  - scan_dir=1: scan 5->0, wrap to 5, frame_tick on the wrap to 5.
  - scan_dir is sampled only in advance cycles. A change mid-dwell takes effect at the next advance, stepping from the current index in the new direction.
  - Reset value of digit_sel is still 0.
- Undefined: no scan_dir port; forward scan only; logic identical to scan_dir tied 0.

Test Plan:
- Reset, DIV=4: hold rst_n=0 for 3 cycles, release -> digit_sel=0, digit_val=0, frame_tick=0. digit_sel steps every 4 cycles: 0,1,2,3,4,5,0. frame_tick is one pulse each 24 cycles.
- Fill, DIV=4: write addr 0..5 with data 7,6,5,4,3,2 -> over the next frame, digit_val at each digit_sel matches the written value. wr_err stays 0.
- Illegal address: wr_en=1, wr_addr=6, wr_data=5 -> wr_err=1 for exactly one cycle; one full frame shows unchanged digit values.
- Bypass, DIV=4: in the advance cycle from digit 2 to 3, write addr 3 with data 1 -> the edge gives digit_sel=3, digit_val=1. Live update: while digit 3 is shown, write addr 3 with data 6 -> digit_val=6 one cycle later.
- Reset mid-operation: assert rst_n=0 during a write to addr 4 at digit 4 dwell cycle 2 -> outputs are 0 immediately, the addr 4 value reads 0 on a later scan, and the scan restarts at 0.
- SEG7_SCAN_REVERSE_EN defined, DIV=4, scan_dir=1 from reset -> sequence 0,5,4,3,2,1,0,5; frame_tick on each entry to 5. Switching scan_dir to 0 at digit 3 mid-dwell -> next index is 4.
